// File: rtl/lfsr_checker.sv
// rtl/lfsr_checker.sv - serial checker for the 6-bit LFSR PRBS stream (s(t+6)=s(t)^s(t+4)).
// Optional LFSR_CHK_FLYWHEEL_EN: while locked, shift the predicted bit instead of din.
module lfsr_checker #(
  parameter int LOCK_CNT = 8,
  parameter int LOSS_CNT = 3,
  parameter int ERR_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             din,
  input  logic             resync,
  input  logic             clr_err,
  output logic             locked,
  output logic             err_flag,
  output logic [ERR_W-1:0] err_cnt,
  output logic [1:0]       state
);

  localparam logic [1:0] SEED      = 2'd0;
  localparam logic [1:0] VERIFY    = 2'd1;
  localparam logic [1:0] LOCKED_ST = 2'd2;
  localparam logic [7:0] LOCK_V    = 8'(LOCK_CNT);
  localparam logic [3:0] LOSS_V    = 4'(LOSS_CNT);

  logic [5:0] r, r_n;
  logic [2:0] fill_cnt, fill_n;
  logic [7:0] match_cnt, match_n;
  logic [3:0] miss_cnt, miss_n;
  logic [1:0] state_n;
  logic       exp_bit;
  logic       hit;

  assign exp_bit = r[5] ^ r[1];

  always_comb begin
    state_n = state;
    r_n     = r;
    fill_n  = fill_cnt;
    match_n = match_cnt;
    miss_n  = miss_cnt;
    hit     = 1'b0;
    if (resync) begin
      state_n = SEED;
      r_n     = 6'd0;
      fill_n  = 3'd0;
      match_n = 8'd0;
      miss_n  = 4'd0;
    end else if (en) begin
      case (state)
        VERIFY: begin
          r_n = {r[4:0], din};
          if (din == exp_bit) begin
            match_n = match_cnt + 8'd1;
            if (match_n == LOCK_V) begin
              state_n = LOCKED_ST;
              miss_n  = 4'd0;
            end
          end else begin
            state_n = SEED;
            fill_n  = 3'd0;
          end
        end
        LOCKED_ST: begin
`ifdef LFSR_CHK_FLYWHEEL_EN
          r_n = {r[4:0], exp_bit};
`else
          r_n = {r[4:0], din};
`endif
          if (din == exp_bit) begin
            miss_n = 4'd0;
          end else begin
            hit    = 1'b1;
            miss_n = miss_cnt + 4'd1;
            if (miss_n == LOSS_V) begin
              state_n = SEED;
              fill_n  = 3'd0;
              match_n = 8'd0;
            end
          end
        end
        default: begin
          // SEED, and the unused code 3 collapses into SEED here
          state_n = SEED;
          r_n     = {r[4:0], din};
          fill_n  = (fill_cnt == 3'd6) ? 3'd6 : fill_cnt + 3'd1;
          if (fill_n == 3'd6 && r_n != 6'd0) begin
            state_n = VERIFY;
            match_n = 8'd0;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= SEED;
      r         <= 6'd0;
      fill_cnt  <= 3'd0;
      match_cnt <= 8'd0;
      miss_cnt  <= 4'd0;
      locked    <= 1'b0;
      err_flag  <= 1'b0;
      err_cnt   <= '0;
    end else begin
      state     <= state_n;
      r         <= r_n;
      fill_cnt  <= fill_n;
      match_cnt <= match_n;
      miss_cnt  <= miss_n;
      locked    <= (state_n == LOCKED_ST);
      err_flag  <= hit;
      if (clr_err)
        err_cnt <= '0;
      else if (hit && err_cnt != '1)
        err_cnt <= err_cnt + ERR_W'(1);
    end
  end

endmodule

// File: tb/tb_lfsr_checker.sv
// tb/tb_lfsr_checker.sv - scoreboard bench for lfsr_checker, driven by the period-14 reference stream.
// Expected patterns follow LFSR_CHK_FLYWHEEL_EN when it is defined.
module tb_lfsr_checker;

  localparam int EW  = 5;
  localparam int SAT = (1 << EW) - 1;

`ifdef LFSR_CHK_FLYWHEEL_EN
  localparam logic [8:0] SGL_FL   = 9'b000000001;
  localparam logic [8:0] LOSS_FL  = 9'b000000111;
  localparam int         LOSS_LEN = 3;
`else
  // a flip at t mis-predicts t+2 and t+6; three flips lose lock at offset 8
  localparam logic [8:0] SGL_FL   = 9'b001000101;
  localparam logic [8:0] LOSS_FL  = 9'b111011011;
  localparam int         LOSS_LEN = 9;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0;
  logic          din = 1'b0;
  logic          resync = 1'b0;
  logic          clr_err = 1'b0;
  logic          locked;
  logic          err_flag;
  logic [EW-1:0] err_cnt;
  logic [1:0]    state;

  lfsr_checker #(.LOCK_CNT(8), .LOSS_CNT(3), .ERR_W(EW)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .din(din), .resync(resync), .clr_err(clr_err),
    .locked(locked), .err_flag(err_flag), .err_cnt(err_cnt), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct { int st; int lk; int fl; int cnt; } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   pos = 0;
  int   raw_cnt = 0;
  int   seq [14] = '{1, 0, 0, 0, 0, 0, 1, 0, 1, 0, 1, 0, 0, 0};
  logic en_q = 1'b0;

  function automatic int sat(input int c);
    return (c > SAT) ? SAT : c;
  endfunction

  task automatic cmp(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, expv, $time);
    end
  endtask

  always @(posedge clk) en_q <= en && !resync && rst_n;

  always @(negedge clk) begin : monitor
    exp_t e;
    if (en_q) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_underflow actual=empty required=entry at %0t", $time);
      end else begin
        e = q.pop_front();
        cmp("sb_state", int'(state), e.st);
        cmp("sb_locked", int'(locked), e.lk);
        cmp("sb_err_flag", int'(err_flag), e.fl);
        cmp("sb_err_cnt", int'(err_cnt), e.cnt);
      end
    end
  end

  task automatic idle();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic b, input int st, input int lk, input int fl, input int cnt);
    exp_t e;
    e.st = st; e.lk = lk; e.fl = fl; e.cnt = cnt;
    q.push_back(e);
    din = b;
    en  = 1'b1;
    @(posedge clk);
    #1;
    en = 1'b0;
  endtask

  task automatic stream(input logic flip, input int st, input int lk, input int fl);
    logic b;
    b = (seq[pos % 14] != 0) ^ flip;
    pos++;
    raw_cnt += fl;
    send(b, st, lk, fl, sat(raw_cnt));
  endtask

  task automatic acquire(input bit bubble);
    for (int i = 0; i < 14; i++) begin
      stream(1'b0, (i < 5) ? 0 : ((i < 13) ? 1 : 2), (i == 13) ? 1 : 0, 0);
      if (bubble) idle();
    end
  endtask

  task automatic single_err();
    for (int k = 0; k < 9; k++)
      stream(k == 0, 2, 1, int'(SGL_FL[k]));
  endtask

  task automatic loss();
    for (int k = 0; k < LOSS_LEN; k++)
      stream(k < 3, (k == LOSS_LEN - 1) ? 0 : 2, (k == LOSS_LEN - 1) ? 0 : 1, int'(LOSS_FL[k]));
  endtask

  task automatic pulse_resync();
    resync = 1'b1;
    idle();
    resync = 1'b0;
  endtask

  task automatic pulse_clr();
    clr_err = 1'b1;
    idle();
    clr_err = 1'b0;
    raw_cnt = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    cmp("rst_state", int'(state), 0);
    cmp("rst_locked", int'(locked), 0);
    cmp("rst_err_cnt", int'(err_cnt), 0);
    cmp("rst_err_flag", int'(err_flag), 0);
    rst_n = 1'b1;
    idle();

    acquire(1'b0);
    repeat (6) stream(1'b0, 2, 1, 0);
    single_err();
    @(negedge clk);
    cmp("single_total", int'(err_cnt), sat(raw_cnt));
    pulse_clr();
    @(negedge clk);
    cmp("clr_idle", int'(err_cnt), 0);

    repeat (4) stream(1'b0, 2, 1, 0);
    loss();
    acquire(1'b0);
    pulse_clr();
    pulse_resync();
    acquire(1'b1);

    single_err();
    pulse_resync();
    @(negedge clk);
    cmp("resync_state", int'(state), 0);
    cmp("resync_locked", int'(locked), 0);
    cmp("resync_err_kept", int'(err_cnt), sat(raw_cnt));

    acquire(1'b0);
    clr_err = 1'b1;
    raw_cnt = 0;
    send(~(seq[pos % 14] != 0), 2, 1, 1, 0);
    pos++;
    clr_err = 1'b0;
    pulse_resync();

    repeat (40) send(1'b0, 0, 0, 0, 0);
    pulse_resync();

    while (raw_cnt < (1 << EW) + 5) begin
      acquire(1'b0);
      loss();
    end
    @(negedge clk);
    cmp("sat_err_cnt", int'(err_cnt), SAT);

    acquire(1'b0);
    idle();
    rst_n = 1'b0;
    #1;
    cmp("async_state", int'(state), 0);
    cmp("async_locked", int'(locked), 0);
    cmp("async_err_cnt", int'(err_cnt), 0);
    cmp("async_err_flag", int'(err_flag), 0);
    #2;
    rst_n = 1'b1;

    repeat (3) idle();
    cmp("sb_drain", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
